// File: rtl/usb_pkg.sv
// Shared constants, state/result enums and CRC5 helpers for the USB token receiver.
// Honours USB_TOKEN_RX_SOF_EN: when defined, SOF (PID 0x5) is a supported token.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_SOF   = 4'h5;

  localparam logic [4:0] CRC5_POLY    = 5'b00101;
  localparam logic [4:0] CRC5_INIT    = 5'b11111;
  localparam logic [4:0] CRC5_RESIDUE = 5'b01100;

  typedef enum logic [2:0] {
    IDLE,
    PID,
    B1,
    B2,
    WAIT_EOP,
    DROP
  } state_e;

  typedef enum logic [1:0] {
    RES_TOK,
    RES_PID,
    RES_LEN,
    RES_CRC
  } res_e;

  // Serial CRC5 unrolled over one byte, bit 0 first as it appears on the wire.
  function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] data);
    logic [4:0] c;
    logic       fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[4] ^ data[i];
      c  = {c[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
    end
    return c;
  endfunction

  function automatic logic pid_supported(input logic [7:0] pid_byte);
    logic ok;
    ok = (pid_byte[3:0] == PID_OUT) || (pid_byte[3:0] == PID_IN) ||
         (pid_byte[3:0] == PID_SETUP);
`ifdef USB_TOKEN_RX_SOF_EN
    ok = ok || (pid_byte[3:0] == PID_SOF);
`endif
    return ok && (pid_byte[7:4] == ~pid_byte[3:0]);
  endfunction

endpackage

// File: rtl/usb_crc5_chk.sv
// Byte-wide CRC5 accumulator; after the token fields and their CRC have been
// fed in, residue equals CRC5_RESIDUE for an intact packet.
module usb_crc5_chk
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [4:0] residue
);

  logic [4:0] crc_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc_q <= CRC5_INIT;
    end else if (en) begin
      crc_q <= crc5_byte(crc_q, data);
    end
  end

  assign residue = crc_q;

endmodule

// File: rtl/usb_token_rx.sv
// USB token packet receiver: PID check, field extraction, CRC5 and length checks.
// Define USB_TOKEN_RX_SOF_EN to accept SOF and drive frame_num; otherwise frame_num is 0.
//
// state    | meaning
// IDLE     | waiting for the PID byte
// PID      | valid PID held, waiting for byte 1
// B1       | byte 1 held, waiting for byte 2
// B2       | all three bytes held, waiting for eop (a 4th byte is a length error)
// WAIT_EOP | eop arrived together with the last byte; result issued this cycle
// DROP     | discarding bytes until eop (bad PID reports then, overlong stays silent)
module usb_token_rx
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_eop,
  input  logic        rx_abort,
  output logic        tok_valid,
  output logic [3:0]  tok_pid,
  output logic [6:0]  tok_addr,
  output logic [3:0]  tok_endp,
  output logic [10:0] frame_num,
  output logic        crc_err,
  output logic        pid_err,
  output logic        len_err,
  output logic        busy
);

  state_e     state;
  logic [3:0] pid_q;
  logic [7:0] byte1_q;
  logic [2:0] endp_hi_q;
  logic [1:0] cnt;
  logic       pid_bad;
  logic       drop_pid;
  logic [4:0] residue;
  logic       crc_clr;
  logic       crc_en;
  logic       fin;
  res_e       fin_kind;

  usb_crc5_chk u_crc (
    .clk     (clk),
    .rst     (rst),
    .clr     (crc_clr),
    .en      (crc_en),
    .data    (rx_data),
    .residue (residue)
  );

  always_comb begin
    crc_clr  = (state == IDLE) || rx_abort;
    crc_en   = rx_valid && !rx_abort && ((state == PID) || (state == B1));
    fin      = 1'b0;
    fin_kind = RES_CRC;
    if (!rx_abort) begin
      case (state)
        PID, B1, B2: fin = rx_eop && !rx_valid;
        WAIT_EOP:    fin = 1'b1;
        default:     fin = 1'b0;
      endcase
    end
    if (pid_bad) begin
      fin_kind = RES_PID;
    end else if (cnt != 2'd3) begin
      fin_kind = RES_LEN;
    end else if (residue == CRC5_RESIDUE) begin
      fin_kind = RES_TOK;
    end
  end

`ifdef USB_TOKEN_RX_SOF_EN
  logic [10:0] frame_q;
  assign frame_num = frame_q;
`else
  assign frame_num = 11'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      tok_valid <= 1'b0;
      pid_err   <= 1'b0;
      crc_err   <= 1'b0;
      len_err   <= 1'b0;
      tok_pid   <= 4'd0;
      tok_addr  <= 7'd0;
      tok_endp  <= 4'd0;
      pid_q     <= 4'd0;
      byte1_q   <= 8'd0;
      endp_hi_q <= 3'd0;
      cnt       <= 2'd0;
      pid_bad   <= 1'b0;
      drop_pid  <= 1'b0;
`ifdef USB_TOKEN_RX_SOF_EN
      frame_q   <= 11'd0;
`endif
    end else begin
      tok_valid <= 1'b0;
      pid_err   <= 1'b0;
      crc_err   <= 1'b0;
      len_err   <= 1'b0;
      if (rx_abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (fin) begin
        state <= IDLE;
        busy  <= 1'b0;
        case (fin_kind)
          RES_TOK: begin
            tok_valid <= 1'b1;
            tok_pid   <= pid_q;
`ifdef USB_TOKEN_RX_SOF_EN
            // SOF carries a frame number in place of addr/endp, which stay put.
            if (pid_q == PID_SOF) begin
              frame_q <= {endp_hi_q, byte1_q};
            end else begin
              tok_addr <= byte1_q[6:0];
              tok_endp <= {endp_hi_q, byte1_q[7]};
            end
`else
            tok_addr <= byte1_q[6:0];
            tok_endp <= {endp_hi_q, byte1_q[7]};
`endif
          end
          RES_PID: pid_err <= 1'b1;
          RES_LEN: len_err <= 1'b1;
          default: crc_err <= 1'b1;
        endcase
      end else begin
        case (state)
          IDLE: begin
            if (rx_valid) begin
              busy     <= 1'b1;
              pid_q    <= rx_data[3:0];
              pid_bad  <= !pid_supported(rx_data);
              drop_pid <= 1'b1;
              cnt      <= 2'd1;
              if (rx_eop)                     state <= WAIT_EOP;
              else if (pid_supported(rx_data)) state <= PID;
              else                            state <= DROP;
            end
          end
          PID: begin
            if (rx_valid) begin
              byte1_q <= rx_data;
              cnt     <= 2'd2;
              state   <= rx_eop ? WAIT_EOP : B1;
            end
          end
          B1: begin
            if (rx_valid) begin
              endp_hi_q <= rx_data[2:0];
              cnt       <= 2'd3;
              state     <= rx_eop ? WAIT_EOP : B2;
            end
          end
          B2: begin
            // Overlong packet: report once now, then swallow the rest silently.
            if (rx_valid) begin
              len_err  <= 1'b1;
              drop_pid <= 1'b0;
              if (rx_eop) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= DROP;
              end
            end
          end
          DROP: begin
            if (rx_eop) begin
              pid_err <= drop_pid;
              state   <= IDLE;
              busy    <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
